// File: rtl/count_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : count_event_logger
// Description : Watches the counter stage's count/result outputs, detects
//               count wrap, result rise, result fall and count stall events,
//               and logs each event cycle with a timestamp into a small FIFO
//               drained through a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_logger #(
  parameter int COUNT_W     = 6,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [COUNT_W-1:0]        count_in,
  input  logic                      result_in,
  input  logic                      evt_ready,
  output logic                      evt_valid,
  output logic [4+COUNT_W+TS_W-1:0] evt_data,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);

  // Entry layout: {mask[3:0], count[COUNT_W-1:0], stamp[TS_W-1:0]}
  localparam int c_ew = 4 + COUNT_W + TS_W;
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_sw = $clog2(STALL_LIMIT);

  localparam logic [COUNT_W-1:0] c_cnt_max   = {COUNT_W{1'b1}};
  localparam logic [c_sw-1:0]    c_stall_max = c_sw'(STALL_LIMIT - 1);
  localparam logic [c_sw-1:0]    c_stall_pre = c_sw'(STALL_LIMIT - 2);
  localparam logic [7:0]         c_drop_sat  = 8'hFF;

  // Mask bit positions
  localparam int c_bit_wrap  = 0;
  localparam int c_bit_rise  = 1;
  localparam int c_bit_fall  = 2;
  localparam int c_bit_stall = 3;

  // Timestamp and sampling state
  logic [TS_W-1:0]    r_ts;
  logic               r_primed;
  logic [COUNT_W-1:0] r_prev_count;
  logic               r_prev_result;
  logic [c_sw-1:0]    r_stall_cnt;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [c_ew-1:0]    r_mem [DEPTH];
  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;

  // Combinational control
  logic               w_active;
  logic               w_same;
  logic [3:0]         w_mask;
  logic               w_push;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr_en;
  logic               w_drop;
  logic [c_ew-1:0]    w_entry;

  // Free-running timestamp, independent of enable
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  // Capture the previous sample; the first enabled edge only primes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_primed      <= 1'b0;
      r_prev_count  <= '0;
      r_prev_result <= 1'b0;
    end else if (enable) begin
      r_primed      <= 1'b1;
      r_prev_count  <= count_in;
      r_prev_result <= result_in;
    end else begin
      r_primed      <= 1'b0;
    end
  end

  // Stall counter: counts unchanged-count edges, saturates so the event fires once
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!w_active || !w_same) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != c_stall_max) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Event detection against the previous sample
  always_comb begin
    w_active             = enable && r_primed;
    w_same               = (count_in == r_prev_count);
    w_mask               = 4'b0000;
    w_mask[c_bit_wrap]   = (r_prev_count == c_cnt_max) && (count_in == '0);
    w_mask[c_bit_rise]   = !r_prev_result && result_in;
    w_mask[c_bit_fall]   = r_prev_result && !result_in;
    w_mask[c_bit_stall]  = w_same && (r_stall_cnt == c_stall_pre);
    w_push               = w_active && (w_mask != 4'b0000);
    w_entry              = {w_mask, count_in, r_ts};
  end

  // FIFO status and handshake decode
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
              (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    w_pop   = !w_empty && evt_ready;
    // A pop on the same edge frees the slot the push needs
    w_wr_en = w_push && (!w_full || w_pop);
    w_drop  = w_push && w_full && !w_pop;
  end

  // FIFO storage write; contents need no reset since the pointers gate reads
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= w_entry;
    end
  end

  // FIFO pointer update; reset discards any queued entries
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != c_drop_sat) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Head-of-queue presentation; zero data when empty
  always_comb begin
    evt_valid = !w_empty;
    evt_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
    overflow  = r_overflow;
    drop_cnt  = r_drop_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_count_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_event_logger
// Description : Scoreboard bench for count_event_logger. Expected entries are
//               queued when the causing stimulus is driven and compared as the
//               DUT presents them on the drain port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_event_logger;

  localparam int COUNT_W     = 6;
  localparam int TS_W        = 16;
  localparam int DEPTH       = 8;
  localparam int STALL_LIMIT = 16;
  localparam int EW          = 4 + COUNT_W + TS_W;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [COUNT_W-1:0] count_in;
  logic               result_in;
  logic               evt_ready;
  logic               evt_valid;
  logic [EW-1:0]      evt_data;
  logic               overflow;
  logic [7:0]         drop_cnt;

  logic [TS_W-1:0]    tb_ts;
  logic [EW-1:0]      sb [$];
  int                 checks = 0;
  int                 errors = 0;

  count_event_logger #(
    .COUNT_W(COUNT_W), .TS_W(TS_W), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .count_in(count_in),
    .result_in(result_in), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_data(evt_data), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  // Reference timestamp: value read before an edge is the stamp of that edge
  always @(posedge clock) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 1'b1;
  end

  function automatic logic [EW-1:0] ent(input logic [3:0] m, input logic [COUNT_W-1:0] c,
                                        input logic [TS_W-1:0] s);
    return {m, c, s};
  endfunction

  task automatic drain(input int n, input string name);
    int got;
    logic [EW-1:0] exp;
    got = 0;
    evt_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!evt_valid && sb.size() == 0) break;
      if (evt_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_unexpected got %h want none", name, evt_data);
        end else begin
          exp = sb.pop_front();
          if (evt_data !== exp) begin
            errors++;
            $display("FAIL %s_entry%0d got %h want %h", name, got, evt_data, exp);
          end
        end
        got++;
      end
      @(negedge clock);
    end
    evt_ready = 1'b0;
    checks++;
    if (got !== n) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", name, got, n);
    end
    checks++;
    if (evt_valid !== 1'b0 || evt_data !== '0) begin
      errors++;
      $display("FAIL %s_empty got valid=%b data=%h want valid=0 data=0", name, evt_valid, evt_data);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got %0d left want 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; evt_ready = 1'b0; count_in = '0; result_in = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    checks++;
    if (evt_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", evt_data); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_wrap();
    reset = 1'b0; enable = 1'b1; count_in = 6'd62;
    @(negedge clock);
    count_in = 6'd63;
    @(negedge clock);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL wrap_early got %b want 0", evt_valid); end
    count_in = 6'd0;
    sb.push_back(ent(4'b0001, 6'd0, 16'd2));
    @(negedge clock);
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL wrap_latency got %b want 1", evt_valid); end
    enable = 1'b0;
    drain(1, "wrap");
  endtask

  task automatic test_wrap_rise();
    enable = 1'b1; count_in = 6'd62; result_in = 1'b0;
    @(negedge clock);
    count_in = 6'd63;
    @(negedge clock);
    count_in = 6'd0; result_in = 1'b1;
    sb.push_back(ent(4'b0011, 6'd0, tb_ts));
    @(negedge clock);
    enable = 1'b0;
    drain(1, "wrap_rise");
  endtask

  task automatic test_stall();
    enable = 1'b1; result_in = 1'b0; count_in = 6'd5;
    for (int i = 1; i <= 20; i++) begin
      if (i == STALL_LIMIT) sb.push_back(ent(4'b1000, 6'd5, tb_ts));
      @(negedge clock);
    end
    count_in = 6'd6;
    for (int i = 1; i <= 20; i++) begin
      if (i == STALL_LIMIT) sb.push_back(ent(4'b1000, 6'd6, tb_ts));
      @(negedge clock);
    end
    enable = 1'b0;
    drain(2, "stall");
  endtask

  task automatic test_overflow();
    enable = 1'b1; evt_ready = 1'b0; count_in = 6'd10; result_in = 1'b0;
    @(negedge clock);
    for (int i = 1; i <= 10; i++) begin
      result_in = ~result_in;
      if (i <= DEPTH) sb.push_back(ent(result_in ? 4'b0010 : 4'b0100, 6'd10, tb_ts));
      @(negedge clock);
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++;
    if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", evt_valid); end
  endtask

  task automatic test_full_pushpop();
    logic [EW-1:0] exp;
    exp = sb.pop_front();
    checks++;
    if (evt_data !== exp) begin errors++; $display("FAIL full_head got %h want %h", evt_data, exp); end
    evt_ready = 1'b1;
    result_in = 1'b1;
    sb.push_back(ent(4'b0010, 6'd10, tb_ts));
    @(negedge clock);
    evt_ready = 1'b0; enable = 1'b0;
    checks++;
    if (drop_cnt !== 8'd2) begin errors++; $display("FAIL full_drop got %0d want 2", drop_cnt); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", overflow); end
    drain(DEPTH, "full");
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; evt_ready = 1'b0; count_in = 6'd63; result_in = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      result_in = ~result_in;
      @(negedge clock);
    end
    checks++;
    if (evt_valid !== 1'b1) begin errors++; $display("FAIL rmid_queued got %b want 1", evt_valid); end
    reset = 1'b1; count_in = 6'd0;
    @(negedge clock);
    checks++;
    if (evt_valid !== 1'b0 || evt_data !== '0) begin
      errors++; $display("FAIL rmid_valid got valid=%b data=%h want 0/0", evt_valid, evt_data);
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got %b want 0", overflow); end
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop got %0d want 0", drop_cnt); end
    reset = 1'b0;
    @(negedge clock);
    count_in = 6'd1;
    @(negedge clock);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_prime got %b want 0", evt_valid); end
    count_in = 6'd63;
    @(negedge clock);
    count_in = 6'd0;
    sb.push_back(ent(4'b0001, 6'd0, 16'd3));
    @(negedge clock);
    enable = 1'b0;
    drain(1, "rmid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_wrap_rise();
    test_stall();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
